hpi_bus_arbiter: RTL and testbench
==================================

# hpi_bus_arbiter

Sequencer and two-port arbiter for the CY7C67200 Host Port Interface (HPI). It turns single-word read/write requests into correctly timed HPI bus cycles on the address, data, chip-select and strobe pins. Requester 0 is the CPU-side bridge (PIO path); requester 1 is a hardware keyboard poller. The block sits between the SoC fabric and the top-level HPI tristate pad logic.

## Interface
- SETUP_CYC, 1: cycles CS asserted before strobe; legal 1..15
- STROBE_CYC, 4: cycles RD/WR strobe held low; legal 1..15
- HOLD_CYC, 1: cycles CS held after strobe release; legal 1..15

Ports:
- clk_clk  in  1  system clock (50 MHz)
- reset_reset_n  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1 each  request pending; held until matching done
- req0_write, req1_write  in  1 each  1 = write, 0 = read
- req0_addr, req1_addr  in  2 each  HPI register select (0 data, 1 mailbox, 2 address, 3 status)
- req0_wdata, req1_wdata  in  16 each  write data
- req0_done, req1_done  out  1 each  one-cycle completion pulse
- rdata  out  16  read data; valid on a done pulse of a read, held until next read completes
- otg_hpi_address  out  2  HPI address pins
- otg_hpi_data_out  out  16  write data to pad
- otg_hpi_data_oe  out  1  pad output enable
- otg_hpi_data_in  in  16  read data from pad
- otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n  out  1 each  active-low chip select, read strobe, write strobe

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: when any reqN_valid is high, grant one requester and latch its write, addr and wdata into internal registers. Go to SETUP. The down-counter loads SETUP_CYC-1.
- Arbitration: round-robin. When both requesters are valid, grant the one not granted last. The last-grant pointer resets to 1, so req0 wins the first tie.
- SETUP: cs_n=0. The counter decrements each cycle. At 0, go to STROBE and load STROBE_CYC-1.
- STROBE: cs_n=0. r_n=0 for a read; w_n=0 for a write. On the final STROBE cycle (counter==0), capture otg_hpi_data_in into rdata for a read. Then go to HOLD and load HOLD_CYC-1.
- HOLD: cs_n=0, strobes high. At 0, go to DONE.
- DONE: cs_n=1. Pulse reqN_done for the granted requester. Go to IDLE.
- otg_hpi_address and otg_hpi_data_out are driven from the latched registers from SETUP through HOLD. Both are held stable while cs_n is low.
- otg_hpi_data_oe is 1 in SETUP, STROBE and HOLD for writes only; otherwise 0.
- Requester inputs are ignored outside IDLE. Changes to addr or data after grant have no effect.
- rdata is unchanged by write transactions.
- Reset (any state, including mid-cycle): return to IDLE asynchronously and drop the transaction. No done pulse is issued for the dropped transaction.

## Timing
- Reset values: cs_n=1, r_n=1, w_n=1, data_oe=0, otg_hpi_address=0, otg_hpi_data_out=0, rdata=0, req0_done=0, req1_done=0.
- All outputs are registered. No combinational path exists from a request input to a pad pin.
- Latency from the valid sample in IDLE to the done pulse is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (7 at defaults).
- There is one mandatory cs_n-high cycle (DONE) plus one IDLE cycle between back-to-back transactions. Throughput is one word per 2+SETUP+STROBE+HOLD cycles.
- A requester that keeps valid high in the cycle after its done pulse is seen as a new request.

## Configuration
- HPI_ARB_FIXED_PRIO_EN defined: fixed priority. req0 always wins ties, and the last-grant pointer is not implemented.
- HPI_ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.

## Test plan
- Single write, req0 with addr=2 and wdata=0x1234: cs_n is low for exactly 6 cycles; w_n is low for 4 cycles starting 1 cycle after cs_n falls; data_oe=1 and pad data=0x1234 throughout; req0_done pulses 7 cycles after valid; r_n stays 1.
- Single read, req1 with addr=0 and pad driving 0xBEEF during strobe: r_n is low for 4 cycles; data_oe=0; rdata=0xBEEF at the req1_done pulse; rdata is unchanged by a following write.
- Both requesters valid from reset with continuous requests: grants alternate 0,1,0,1 for 4 transactions. With HPI_ARB_FIXED_PRIO_EN defined, only req0 is serviced while it remains valid.
- Requester changes addr/wdata from 1/0x00FF to 3/0xFFFF one cycle after grant: pins keep 1/0x00FF for the whole cycle.
- Assert reset_reset_n low during STROBE of a write: cs_n, w_n and data_oe go inactive immediately without a clock edge; no done pulse occurs; after release, a new req1 read completes normally.
- Parameters SETUP=2, STROBE=1, HOLD=3: cs_n is low for 6 cycles; the strobe is 1 cycle wide, starting on the third cs_n-low cycle.

Source files
------------

// File: rtl/hpi_bus_arbiter_if.sv
// rtl/hpi_bus_arbiter_if.sv - requester handshake and HPI pad bundle for hpi_bus_arbiter
interface hpi_bus_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_write;
    logic        req1_write;
    logic [1:0]  req0_addr;
    logic [1:0]  req1_addr;
    logic [15:0] req0_wdata;
    logic [15:0] req1_wdata;
    logic        req0_done;
    logic        req1_done;
    logic [15:0] rdata;
    logic [1:0]  otg_hpi_address;
    logic [15:0] otg_hpi_data_out;
    logic        otg_hpi_data_oe;
    logic [15:0] otg_hpi_data_in;
    logic        otg_hpi_cs_n;
    logic        otg_hpi_r_n;
    logic        otg_hpi_w_n;

    modport slave (
        input  req0_valid, req1_valid, req0_write, req1_write,
        input  req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  otg_hpi_data_in,
        output req0_done, req1_done, rdata,
        output otg_hpi_address, otg_hpi_data_out, otg_hpi_data_oe,
        output otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n
    );

    modport master (
        output req0_valid, req1_valid, req0_write, req1_write,
        output req0_addr, req1_addr, req0_wdata, req1_wdata,
        output otg_hpi_data_in,
        input  req0_done, req1_done, rdata,
        input  otg_hpi_address, otg_hpi_data_out, otg_hpi_data_oe,
        input  otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n
    );
endinterface

// File: rtl/hpi_bus_arbiter.sv
// rtl/hpi_bus_arbiter.sv - two-port HPI bus cycle sequencer; HPI_ARB_FIXED_PRIO_EN selects fixed priority
module hpi_bus_arbiter #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    hpi_bus_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        write_q, write_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        r_n_q, r_n_d;
    logic        w_n_q, w_n_d;
    logic        oe_q, oe_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        grant_sel;
`ifndef HPI_ARB_FIXED_PRIO_EN
    logic        last_q, last_d;
`endif

    // Next-state, transaction latch and registered pad/handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef HPI_ARB_FIXED_PRIO_EN
        grant_sel = !bus.req0_valid;
`else
        last_d = last_q;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_q;
        end else begin
            grant_sel = !bus.req0_valid;
        end
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    gnt_d   = grant_sel;
                    write_d = grant_sel ? bus.req1_write : bus.req0_write;
                    addr_d  = grant_sel ? bus.req1_addr  : bus.req0_addr;
                    wdata_d = grant_sel ? bus.req1_wdata : bus.req0_wdata;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
`ifndef HPI_ARB_FIXED_PRIO_EN
                    last_d  = grant_sel;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!write_q) begin
                        rdata_d = bus.otg_hpi_data_in;
                    end
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Pins are computed from the next state so they change in step with it
        cs_n_d  = !(state_d == SETUP || state_d == STROBE || state_d == HOLD);
        r_n_d   = !(state_d == STROBE && !write_d);
        w_n_d   = !(state_d == STROBE && write_d);
        oe_d    = !cs_n_d && write_d;
        done0_d = (state_d == DONE) && !gnt_d;
        done1_d = (state_d == DONE) && gnt_d;
    end

    // State, latch and output registers; reset drops any transaction in flight
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            cs_n_q  <= 1'b1;
            r_n_q   <= 1'b1;
            w_n_q   <= 1'b1;
            oe_q    <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifndef HPI_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            r_n_q   <= r_n_d;
            w_n_q   <= w_n_d;
            oe_q    <= oe_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifndef HPI_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.otg_hpi_address  = addr_q;
    assign bus.otg_hpi_data_out = wdata_q;
    assign bus.otg_hpi_data_oe  = oe_q;
    assign bus.otg_hpi_cs_n     = cs_n_q;
    assign bus.otg_hpi_r_n      = r_n_q;
    assign bus.otg_hpi_w_n      = w_n_q;
    assign bus.req0_done        = done0_q;
    assign bus.req1_done        = done1_q;
    assign bus.rdata            = rdata_q;
endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// tb/tb_hpi_bus_arbiter.sv - directed self-checking bench for hpi_bus_arbiter
module tb_hpi_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hpi_bus_arbiter_if bi ();
    hpi_bus_arbiter_if bj ();

    hpi_bus_arbiter dut (.clk_clk(clk), .reset_reset_n(rst_n), .bus(bi));
    hpi_bus_arbiter #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .bus(bj));

    int n_asrt = 0;
    int n_fail = 0;
    int cs_cnt, cs_first, wn_cnt, wn_first, rn_cnt, rn_first, bad, d0_idx, d1_idx;
    logic [15:0] rd_at_done;
    int dq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample n cycles of one DUT, drive pad read data during r_n low and
    // drop a requester's valid on its done pulse unless keep is set.
    task automatic observe(input int n, input bit sel, input bit keep, input logic [15:0] pad,
                           input logic [1:0] ea, input logic [15:0] ed, input logic eo);
        logic cs, rn, wn, oe, d0, d1;
        logic [1:0] ad;
        logic [15:0] dout, rd;
        cs_cnt = 0; cs_first = -1; wn_cnt = 0; wn_first = -1; rn_cnt = 0; rn_first = -1;
        bad = 0; d0_idx = -1; d1_idx = -1; rd_at_done = 16'hxxxx;
        dq.delete();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (sel) begin
                cs = bj.otg_hpi_cs_n; rn = bj.otg_hpi_r_n; wn = bj.otg_hpi_w_n; oe = bj.otg_hpi_data_oe;
                ad = bj.otg_hpi_address; dout = bj.otg_hpi_data_out; rd = bj.rdata;
                d0 = bj.req0_done; d1 = bj.req1_done;
            end else begin
                cs = bi.otg_hpi_cs_n; rn = bi.otg_hpi_r_n; wn = bi.otg_hpi_w_n; oe = bi.otg_hpi_data_oe;
                ad = bi.otg_hpi_address; dout = bi.otg_hpi_data_out; rd = bi.rdata;
                d0 = bi.req0_done; d1 = bi.req1_done;
            end
            if (!cs) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = k;
                if (ad !== ea || oe !== eo || (eo && dout !== ed)) bad++;
            end
            if (!wn) begin wn_cnt++; if (wn_first < 0) wn_first = k; end
            if (!rn) begin rn_cnt++; if (rn_first < 0) rn_first = k; end
            if (d0) begin dq.push_back(0); if (d0_idx < 0) begin d0_idx = k; rd_at_done = rd; end end
            if (d1) begin dq.push_back(1); if (d1_idx < 0) begin d1_idx = k; rd_at_done = rd; end end
            if (sel) begin
                bj.otg_hpi_data_in = rn ? 16'h0000 : pad;
                if (!keep && d0) bj.req0_valid = 1'b0;
                if (!keep && d1) bj.req1_valid = 1'b0;
            end else begin
                bi.otg_hpi_data_in = rn ? 16'h0000 : pad;
                if (!keep && d0) bi.req0_valid = 1'b0;
                if (!keep && d1) bi.req1_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bi.req0_valid = 0; bi.req1_valid = 0; bi.req0_write = 0; bi.req1_write = 0;
        bi.req0_addr = 0; bi.req1_addr = 0; bi.req0_wdata = 0; bi.req1_wdata = 0; bi.otg_hpi_data_in = 0;
        bj.req0_valid = 0; bj.req1_valid = 0; bj.req0_write = 0; bj.req1_write = 0;
        bj.req0_addr = 0; bj.req1_addr = 0; bj.req0_wdata = 0; bj.req1_wdata = 0; bj.otg_hpi_data_in = 0;
        #12;
        check("rst_cs_n", bi.otg_hpi_cs_n, 1);
        check("rst_r_n", bi.otg_hpi_r_n, 1);
        check("rst_w_n", bi.otg_hpi_w_n, 1);
        check("rst_oe", bi.otg_hpi_data_oe, 0);
        check("rst_addr", bi.otg_hpi_address, 0);
        check("rst_dout", bi.otg_hpi_data_out, 0);
        check("rst_rdata", bi.rdata, 0);
        check("rst_done0", bi.req0_done, 0);
        check("rst_done1", bi.req1_done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // single write from req0
        bi.req0_write = 1; bi.req0_addr = 2; bi.req0_wdata = 16'h1234; bi.req0_valid = 1;
        observe(9, 0, 0, 16'h0000, 2'd2, 16'h1234, 1'b1);
        check("wr_cs_cnt", cs_cnt, 6);
        check("wr_cs_first", cs_first, 0);
        check("wr_wn_cnt", wn_cnt, 4);
        check("wr_wn_first", wn_first, 1);
        check("wr_rn_cnt", rn_cnt, 0);
        check("wr_pins_bad", bad, 0);
        check("wr_done0_idx", d0_idx, 6);
        check("wr_done1_idx", d1_idx, -1);

        // single read from req1
        bi.req1_write = 0; bi.req1_addr = 0; bi.req1_wdata = 0; bi.req1_valid = 1;
        observe(9, 0, 0, 16'hBEEF, 2'd0, 16'h0000, 1'b0);
        check("rd_rn_cnt", rn_cnt, 4);
        check("rd_rn_first", rn_first, 1);
        check("rd_wn_cnt", wn_cnt, 0);
        check("rd_pins_bad", bad, 0);
        check("rd_done1_idx", d1_idx, 6);
        check("rd_rdata", rd_at_done, 16'hBEEF);

        // following write leaves rdata alone
        bi.req0_write = 1; bi.req0_addr = 1; bi.req0_wdata = 16'h5555; bi.req0_valid = 1;
        observe(9, 0, 0, 16'h0000, 2'd1, 16'h5555, 1'b1);
        check("wr2_done0_idx", d0_idx, 6);
        check("wr2_rdata_kept", bi.rdata, 16'hBEEF);

        // arbitration with both requesters continuously valid from reset
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bi.req0_write = 1; bi.req0_addr = 0; bi.req0_wdata = 16'h0001;
        bi.req1_write = 1; bi.req1_addr = 3; bi.req1_wdata = 16'h0002;
        bi.req0_valid = 1; bi.req1_valid = 1;
        observe(32, 0, 1, 16'h0000, 2'd0, 16'h0000, 1'b0);
        bi.req0_valid = 0; bi.req1_valid = 0;
        check("arb_count", dq.size(), 4);
        for (int i = 0; i < 4 && i < dq.size(); i++) begin
`ifdef HPI_ARB_FIXED_PRIO_EN
            check($sformatf("arb_grant%0d", i), dq[i], 0);
`else
            check($sformatf("arb_grant%0d", i), dq[i], i % 2);
`endif
        end
        repeat (10) @(posedge clk);
        #1;

        // addr/wdata changes after grant are ignored
        bi.req0_write = 1; bi.req0_addr = 1; bi.req0_wdata = 16'h00FF; bi.req0_valid = 1;
        @(posedge clk); #1;
        check("chg_addr_c1", bi.otg_hpi_address, 1);
        check("chg_dout_c1", bi.otg_hpi_data_out, 16'h00FF);
        bi.req0_addr = 3; bi.req0_wdata = 16'hFFFF;
        observe(8, 0, 0, 16'h0000, 2'd1, 16'h00FF, 1'b1);
        check("chg_cs_cnt", cs_cnt, 5);
        check("chg_pins_bad", bad, 0);
        check("chg_done0_idx", d0_idx, 5);

        // asynchronous reset during STROBE of a write
        bi.req0_write = 1; bi.req0_addr = 2; bi.req0_wdata = 16'hABCD; bi.req0_valid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ar_wn_active", bi.otg_hpi_w_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_cs_n", bi.otg_hpi_cs_n, 1);
        check("ar_w_n", bi.otg_hpi_w_n, 1);
        check("ar_oe", bi.otg_hpi_data_oe, 0);
        bi.req0_valid = 0;
        @(negedge clk) rst_n = 1'b1;
        observe(10, 0, 0, 16'h0000, 2'd0, 16'h0000, 1'b0);
        check("ar_no_done", dq.size(), 0);
        check("ar_cs_idle", cs_cnt, 0);
        bi.req1_write = 0; bi.req1_addr = 0; bi.req1_wdata = 0; bi.req1_valid = 1;
        observe(9, 0, 0, 16'hA5A5, 2'd0, 16'h0000, 1'b0);
        check("ar_rd_done1_idx", d1_idx, 6);
        check("ar_rd_rn_cnt", rn_cnt, 4);
        check("ar_rd_rdata", rd_at_done, 16'hA5A5);

        // alternate timing parameters SETUP=2 STROBE=1 HOLD=3
        bj.req0_write = 1; bj.req0_addr = 2; bj.req0_wdata = 16'h3C3C; bj.req0_valid = 1;
        observe(9, 1, 0, 16'h0000, 2'd2, 16'h3C3C, 1'b1);
        check("p2_cs_cnt", cs_cnt, 6);
        check("p2_cs_first", cs_first, 0);
        check("p2_wn_cnt", wn_cnt, 1);
        check("p2_wn_first", wn_first, 2);
        check("p2_pins_bad", bad, 0);
        check("p2_done0_idx", d0_idx, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
